// File: rtl/alu_muldiv_pkg.sv
// Shared types and constants for the sequential multiply/divide unit.
// The divide path is built only when ALU_MULDIV_DIV_EN is defined.
package alu_muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_AND = 3'b111;

    localparam logic OP_MUL = 1'b0;
    localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/alu_muldiv_if.sv
// Request/result handshake plus the borrowed-ALU operand bus of the muldiv sequencer.
interface alu_muldiv_if #(parameter int WIDTH = 16);

    logic             start;
    logic             op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic             hold;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] res_hi;
    logic [WIDTH-1:0] res_lo;
    logic             dz;
    logic             alu_own;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [2:0]       alu_Op;
    logic             alu_Cin;
    logic             alu_invA;
    logic             alu_invB;
    logic [WIDTH-1:0] alu_Out;
    logic             alu_Cout;

    modport slave (
        input  start, op, opa, opb, hold, alu_Out, alu_Cout,
        output busy, done, res_hi, res_lo, dz, alu_own,
               alu_A, alu_B, alu_Op, alu_Cin, alu_invA, alu_invB
    );

    modport master (
        output start, op, opa, opb, hold, alu_Out, alu_Cout,
        input  busy, done, res_hi, res_lo, dz, alu_own,
               alu_A, alu_B, alu_Op, alu_Cin, alu_invA, alu_invB
    );

endinterface

// File: rtl/alu_muldiv_dp.sv
// Shift-add multiply / restoring divide datapath: hi/lo/operand registers and the
// per-iteration next-value muxing around the externally supplied ALU result.
module alu_muldiv_dp #(
    parameter int WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic             i_load_div,
    input  logic             i_step,
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_opa,
    input  logic [WIDTH-1:0] i_opb,
    input  logic [WIDTH-1:0] i_alu_out,
    input  logic             i_alu_cout,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    output logic [WIDTH-1:0] o_hi_nxt,
    output logic [WIDTH-1:0] o_lo_nxt
);

    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_s;
    logic             w_c;
    logic             w_take;

    // Next hi/lo for one iteration; div treats {hi,lo[15]} as the 17-bit trial value.
    always_comb begin
        w_alu_a  = r_hi;
        w_s      = r_hi;
        w_c      = 1'b0;
        w_take   = 1'b0;
        o_hi_nxt = r_hi;
        o_lo_nxt = r_lo;
        if (i_is_div) begin
            w_alu_a  = {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
            w_take   = r_hi[WIDTH-1] | i_alu_cout;
            if (w_take) begin
                o_hi_nxt = i_alu_out;
            end else begin
                o_hi_nxt = w_alu_a;
            end
            o_lo_nxt = {r_lo[WIDTH-2:0], w_take};
        end else begin
            if (r_lo[0]) begin
                w_c = i_alu_cout;
                w_s = i_alu_out;
            end else begin
                w_c = 1'b0;
                w_s = r_hi;
            end
            o_hi_nxt = {w_c, w_s[WIDTH-1:1]};
            o_lo_nxt = {w_s[0], r_lo[WIDTH-1:1]};
        end
    end

    // Operand capture on accept, one iteration per un-held RUN cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_hi <= {WIDTH{1'b0}};
            r_lo <= {WIDTH{1'b0}};
            r_m  <= {WIDTH{1'b0}};
        end else if (i_load) begin
            r_hi <= {WIDTH{1'b0}};
            r_lo <= i_load_div ? i_opa : i_opb;
            r_m  <= i_load_div ? i_opb : i_opa;
        end else if (i_step) begin
            r_hi <= o_hi_nxt;
            r_lo <= o_lo_nxt;
        end
    end

    assign o_alu_a = w_alu_a;
    assign o_alu_b = r_m;

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 16-bit unsigned multiply/divide sequencer driving a shared ALU.
// Define ALU_MULDIV_DIV_EN to build the divide path and divide-by-zero flag.
module alu_muldiv_seq
    import alu_muldiv_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic          i_clk,
    input  logic          i_rst,
    alu_muldiv_if.slave   bus
);

`ifdef ALU_MULDIV_DIV_EN
    localparam logic DIV_EN = 1'b1;
`else
    localparam logic DIV_EN = 1'b0;
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_is_div;
    logic [WIDTH-1:0] r_res_hi;
    logic [WIDTH-1:0] r_res_lo;
    logic             w_accept;
    logic             w_load_div;
    logic             w_step;
    logic             w_last;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH-1:0] w_alu_a;
    logic [WIDTH-1:0] w_alu_b;

    assign w_load_div = (bus.op == OP_DIV) & DIV_EN;
    assign w_accept   = bus.start & (r_state == IDLE) & ((bus.op == OP_MUL) | DIV_EN);
    assign w_step     = (r_state == RUN) & ~bus.hold;
    assign w_last     = w_step & (r_cnt == {CNT_W{1'b1}});

    // State register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = RUN;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = DONE;
                end else begin
                    w_state_nxt = RUN;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Iteration counter, status flags and result capture.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_is_div <= 1'b0;
            r_res_hi <= {WIDTH{1'b0}};
            r_res_lo <= {WIDTH{1'b0}};
        end else begin
            r_done <= w_last;
            if (w_accept) begin
                r_cnt    <= {CNT_W{1'b0}};
                r_busy   <= 1'b1;
                r_is_div <= w_load_div;
                r_res_hi <= {WIDTH{1'b0}};
                r_res_lo <= {WIDTH{1'b0}};
            end else begin
                if (w_step) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (w_last) begin
                    r_res_hi <= w_hi_nxt;
                    r_res_lo <= w_lo_nxt;
                end
                if (r_state == DONE) begin
                    r_busy <= 1'b0;
                end
            end
        end
    end

    alu_muldiv_dp #(.WIDTH(WIDTH)) u_dp (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (w_accept),
        .i_load_div (w_load_div),
        .i_step     (w_step),
        .i_is_div   (r_is_div),
        .i_opa      (bus.opa),
        .i_opb      (bus.opb),
        .i_alu_out  (bus.alu_Out),
        .i_alu_cout (bus.alu_Cout),
        .o_alu_a    (w_alu_a),
        .o_alu_b    (w_alu_b),
        .o_hi_nxt   (w_hi_nxt),
        .o_lo_nxt   (w_lo_nxt)
    );

`ifdef ALU_MULDIV_DIV_EN
    logic r_dz;

    // Divide-by-zero flag, decided at accept and held until the next accept.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_dz <= 1'b0;
        end else if (w_accept) begin
            r_dz <= w_load_div & (bus.opb == {WIDTH{1'b0}});
        end
    end

    assign bus.dz       = r_dz;
    assign bus.alu_Cin  = r_is_div;
    assign bus.alu_invB = r_is_div;
`else
    assign bus.dz       = 1'b0;
    assign bus.alu_Cin  = 1'b0;
    assign bus.alu_invB = 1'b0;
`endif

    assign bus.busy     = r_busy;
    assign bus.done     = r_done;
    assign bus.res_hi   = r_res_hi;
    assign bus.res_lo   = r_res_lo;
    assign bus.alu_own  = (r_state == RUN) & ~bus.hold;
    assign bus.alu_A    = w_alu_a;
    assign bus.alu_B    = w_alu_b;
    assign bus.alu_Op   = OP_ADD;
    assign bus.alu_invA = 1'b0;

endmodule
